mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
// - Shares one memory bus (address/size/mem_read/mem_write, read-back data) between two requesters.
// - Requester 0 is instruction fetch (read only); requester 1 is the data port (read/write).
// - Sequences each access over a fixed device read latency and returns data with a one-cycle valid.
// - Sits between the core and the address-decoded ROM/RAM devices that share the 64-bit data bus.
// PARAMETERS
// - ADDR_WIDTH    32  bus and request address width
// - DATA_WIDTH    64  data bus width
// - READ_LATENCY  1   clocks from bus drive to bus_rdata sample; legal range 1..15
// PORTS
// - clock        in   1   single clock, all state updates on posedge
// - reset        in   1   synchronous, active-high
// - req0_valid   in   1   fetch request; held with req0_addr/req0_size until req0_ready
// - req0_addr    in   AW  fetch address
// - req0_size    in   2   access size code, forwarded to bus_size unchanged
// - req0_ready   out  1   request accepted this cycle (combinational, IDLE only)
// - rsp0_valid   out  1   one-cycle pulse; rsp0_data valid
// - rsp0_data    out  DW  fetched data
// - req1_valid   in   1   data-port request; held with its fields until req1_ready
// - req1_write   in   1   1 = write, 0 = read
// - req1_addr    in   AW  data address
// - req1_size    in   2   access size code
// - req1_wdata   in   DW  write data
// - req1_ready   out  1   request accepted this cycle
// - rsp1_valid   out  1   one-cycle pulse; read data or write acknowledge
// - rsp1_data    out  DW  read data; 0 for write acknowledge
// - bus_address  out  AW  shared bus address
// - bus_size     out  2   shared bus size
// - bus_mem_read out  1   bus read strobe
// - bus_mem_write out 1   bus write strobe
// - bus_wdata    out  DW  bus write data
// - bus_rdata    in   DW  shared (tristated) read data from the selected device
// - busy         out  1   state != IDLE
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; last_grant = 1, so req0 wins the first tie.
// - States: IDLE -> ACCESS -> RESP -> IDLE. No other transitions except reset.
// - IDLE: winner = req0 or req1 per arbitration; assert winner's reqN_ready for that cycle only.
// - On the accept edge, latch owner, addr, size, write, wdata; set cnt = READ_LATENCY-1 (0 for write).
// - ACCESS: bus_* are driven from latched registers only; bus_mem_read=!write, bus_mem_write=write.
// - ACCESS: cnt != 0 -> decrement; cnt == 0 -> sample bus_rdata (read) or 0 (write) into rsp reg.
// - Then go to RESP.
// - RESP: rspN_valid=1 for owner only, exactly one cycle; bus strobes 0; go to IDLE.
// - Outside ACCESS: bus_address, bus_wdata, bus_mem_read and bus_mem_write are 0.
// - Timing: accept edge T; bus driven cycles T+1..T+L (L=READ_LATENCY; write L=1).
// - Response valid in cycle T+L+1; next accept at the earliest in cycle T+L+2.
// - Requests arriving in ACCESS/RESP wait; ready is never asserted outside IDLE.
// - Both valid in IDLE: one grant; the loser stays pending; no request is ever dropped.
// - last_grant updates to the owner on every accept.
// - rspN_data holds its value until the next response to that requester.
// - Reset mid-access: abort at once, no response, bus strobes 0 next cycle.
// - Requester changes fields before ready: undefined; the bench flags it as a protocol error.
// CONFIGURATION
// - ROUND_ROBIN_EN defined: on a tie, grant the requester != last_grant (strict alternation).
// - ROUND_ROBIN_EN undefined: fixed priority, req1 (data) always wins ties; last_grant unused.
// TESTING
// - Single fetch: L=1, req0 addr=0x10, bus_rdata=0xDEADBEEF_CAFEF00D -> rsp0_valid at T+2 with that data.
// - Latency: L=3, req1 read addr=0x40 -> bus_mem_read high for exactly 3 cycles; rsp1_valid at T+4.
// - Write: req1_write=1, addr=0x80, wdata=0x1234 -> bus_mem_write 1 cycle, rsp1_valid at T+2, data 0.
// - Tie, ROUND_ROBIN_EN: both valid for 4 accesses -> grants 0,1,0,1.
// - Tie, without the macro: same stimulus -> grants 1,1,1,1 while req1 stays valid.
// - Reset in ACCESS: L=3, reset at T+2 -> no rsp pulse; all outputs 0; a new req0 is accepted normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter: fetch (req0, read-only) and data port (req1, read/write).
// Define ROUND_ROBIN_EN for alternating tie-break; otherwise the data port wins ties.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [1:0]            req0_size,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [1:0]            req1_size,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic [ADDR_WIDTH-1:0] bus_address,
  output logic [1:0]            bus_size,
  output logic                  bus_mem_read,
  output logic                  bus_mem_write,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(READ_LATENCY - 1);

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  write_q, write_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rsp0_data_q, rsp0_data_d;
  logic [DATA_WIDTH-1:0] rsp1_data_q, rsp1_data_d;
  logic                  grant0, grant1;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
`ifdef ROUND_ROBIN_EN
      if (req0_valid && req1_valid) begin
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
`else
      grant1 = req1_valid;
      grant0 = req0_valid && !req1_valid;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    write_d      = write_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          owner_d      = grant1;
          last_grant_d = grant1;
          write_d      = grant1 && req1_write;
          addr_d       = grant1 ? req1_addr : req0_addr;
          size_d       = grant1 ? req1_size : req0_size;
          wdata_d      = grant1 ? req1_wdata : '0;
          cnt_d        = (grant1 && req1_write) ? 4'd0 : CNT_INIT;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Write acknowledges carry zero data back to the requester.
          if (owner_q) rsp1_data_d = write_q ? '0 : bus_rdata;
          else         rsp0_data_d = write_q ? '0 : bus_rdata;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      write_q      <= 1'b0;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      write_q      <= write_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  // Latched request fields are only visible through the ACCESS-gated bus outputs.
  always_ff @(posedge clock) begin
    addr_q  <= addr_d;
    size_q  <= size_d;
    wdata_q <= wdata_d;
  end

  assign req0_ready    = grant0;
  assign req1_ready    = grant1;
  assign busy          = (state_q != IDLE);
  assign bus_address   = (state_q == ACCESS) ? addr_q  : '0;
  assign bus_size      = (state_q == ACCESS) ? size_q  : '0;
  assign bus_wdata     = (state_q == ACCESS) ? wdata_q : '0;
  assign bus_mem_read  = (state_q == ACCESS) && !write_q;
  assign bus_mem_write = (state_q == ACCESS) && write_q;
  assign rsp0_valid    = (state_q == RESP) && !owner_q;
  assign rsp1_valid    = (state_q == RESP) && owner_q;
  assign rsp0_data     = rsp0_data_q;
  assign rsp1_data     = rsp1_data_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: instance a uses READ_LATENCY=1, instance b uses 3.
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic          req;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  function automatic logic [DW-1:0] dev_model(input logic [AW-1:0] a);
    if (a == 32'h10) return 64'hDEADBEEF_CAFEF00D;
    return {a ^ 32'h5A5A_0000, ~a};
  endfunction

  logic          a_req0_valid, a_req0_ready, a_rsp0_valid, a_req1_valid, a_req1_write;
  logic          a_req1_ready, a_rsp1_valid, a_mem_read, a_mem_write, a_busy;
  logic [AW-1:0] a_req0_addr, a_req1_addr, a_bus_address;
  logic [1:0]    a_req0_size, a_req1_size, a_bus_size;
  logic [DW-1:0] a_rsp0_data, a_rsp1_data, a_req1_wdata, a_bus_wdata, a_bus_rdata;

  logic          b_req0_valid, b_req0_ready, b_rsp0_valid, b_req1_valid, b_req1_write;
  logic          b_req1_ready, b_rsp1_valid, b_mem_read, b_mem_write, b_busy;
  logic [AW-1:0] b_req0_addr, b_req1_addr, b_bus_address;
  logic [1:0]    b_req0_size, b_req1_size, b_bus_size;
  logic [DW-1:0] b_rsp0_data, b_rsp1_data, b_req1_wdata, b_bus_wdata, b_bus_rdata;

  assign a_bus_rdata = dev_model(a_bus_address);
  assign b_bus_rdata = dev_model(b_bus_address);

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) u_a (
    .clock(clock), .reset(reset),
    .req0_valid(a_req0_valid), .req0_addr(a_req0_addr), .req0_size(a_req0_size),
    .req0_ready(a_req0_ready), .rsp0_valid(a_rsp0_valid), .rsp0_data(a_rsp0_data),
    .req1_valid(a_req1_valid), .req1_write(a_req1_write), .req1_addr(a_req1_addr),
    .req1_size(a_req1_size), .req1_wdata(a_req1_wdata), .req1_ready(a_req1_ready),
    .rsp1_valid(a_rsp1_valid), .rsp1_data(a_rsp1_data),
    .bus_address(a_bus_address), .bus_size(a_bus_size), .bus_mem_read(a_mem_read),
    .bus_mem_write(a_mem_write), .bus_wdata(a_bus_wdata), .bus_rdata(a_bus_rdata),
    .busy(a_busy)
  );

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(3)) u_b (
    .clock(clock), .reset(reset),
    .req0_valid(b_req0_valid), .req0_addr(b_req0_addr), .req0_size(b_req0_size),
    .req0_ready(b_req0_ready), .rsp0_valid(b_rsp0_valid), .rsp0_data(b_rsp0_data),
    .req1_valid(b_req1_valid), .req1_write(b_req1_write), .req1_addr(b_req1_addr),
    .req1_size(b_req1_size), .req1_wdata(b_req1_wdata), .req1_ready(b_req1_ready),
    .rsp1_valid(b_rsp1_valid), .rsp1_data(b_rsp1_data),
    .bus_address(b_bus_address), .bus_size(b_bus_size), .bus_mem_read(b_mem_read),
    .bus_mem_write(b_mem_write), .bus_wdata(b_bus_wdata), .bus_rdata(b_bus_rdata),
    .busy(b_busy)
  );

  // Response monitors: every response pulse must match the oldest expected entry.
  always @(negedge clock) begin
    if (a_rsp0_valid || a_rsp1_valid) begin
      logic [DW-1:0] d;
      exp_t e;
      d = a_rsp1_valid ? a_rsp1_data : a_rsp0_data;
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL sb_a unexpected response req=%0d data=%h cyc=%0d", a_rsp1_valid, d, cyc);
      end else begin
        e = qa.pop_front();
        if ((a_rsp0_valid && a_rsp1_valid) || a_rsp1_valid !== e.req || d !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL sb_a got req=%0d data=%h cyc=%0d expected req=%0d data=%h cyc=%0d",
                   a_rsp1_valid, d, cyc, e.req, e.data, e.cyc);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (b_rsp0_valid || b_rsp1_valid) begin
      logic [DW-1:0] d;
      exp_t e;
      d = b_rsp1_valid ? b_rsp1_data : b_rsp0_data;
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL sb_b unexpected response req=%0d data=%h cyc=%0d", b_rsp1_valid, d, cyc);
      end else begin
        e = qb.pop_front();
        if ((b_rsp0_valid && b_rsp1_valid) || b_rsp1_valid !== e.req || d !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL sb_b got req=%0d data=%h cyc=%0d expected req=%0d data=%h cyc=%0d",
                   b_rsp1_valid, d, cyc, e.req, e.data, e.cyc);
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clock);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain pending a=%0d b=%0d expected 0 0", qa.size(), qb.size());
    end
  endtask

  task automatic test_reset();
    logic [255:0] oa, ob;
    @(negedge clock);
    oa = {a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid, a_rsp0_data[31:0], a_rsp1_data[31:0],
          a_bus_address, a_bus_size, a_mem_read, a_mem_write, a_bus_wdata[31:0], a_busy};
    ob = {b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid, b_rsp0_data[31:0], b_rsp1_data[31:0],
          b_bus_address, b_bus_size, b_mem_read, b_mem_write, b_bus_wdata[31:0], b_busy};
    checks++;
    if (oa !== '0 || a_rsp0_data !== '0 || a_rsp1_data !== '0 || a_bus_wdata !== '0) begin
      errors++;
      $display("FAIL reset_a outputs=%h expected 0", oa);
    end
    checks++;
    if (ob !== '0 || b_rsp0_data !== '0 || b_rsp1_data !== '0 || b_bus_wdata !== '0) begin
      errors++;
      $display("FAIL reset_b outputs=%h expected 0", ob);
    end
  endtask

  task automatic test_single_fetch();
    @(negedge clock);
    a_req0_valid = 1'b1; a_req0_addr = 32'h10; a_req0_size = 2'd3;
    #1;
    checks++;
    if (a_req0_ready !== 1'b1 || a_req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL fetch_ready got %b%b expected 10", a_req0_ready, a_req1_ready);
    end
    qa.push_back('{1'b0, 64'hDEADBEEF_CAFEF00D, cyc + 2});
    @(negedge clock);
    a_req0_valid = 1'b0;
    checks++;
    if (a_mem_read !== 1'b1 || a_mem_write !== 1'b0 || a_bus_address !== 32'h10 ||
        a_bus_size !== 2'd3 || a_busy !== 1'b1 || a_req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL fetch_bus rd=%b wr=%b addr=%h size=%0d busy=%b expected 1 0 10 3 1",
               a_mem_read, a_mem_write, a_bus_address, a_bus_size, a_busy);
    end
    @(negedge clock);
    checks++;
    if (a_rsp0_valid !== 1'b1 || a_mem_read !== 1'b0 || a_bus_address !== '0) begin
      errors++;
      $display("FAIL fetch_resp valid=%b rd=%b addr=%h expected 1 0 0", a_rsp0_valid, a_mem_read, a_bus_address);
    end
    drain();
  endtask

  task automatic test_write();
    @(negedge clock);
    a_req1_valid = 1'b1; a_req1_write = 1'b1; a_req1_addr = 32'h80;
    a_req1_size = 2'd2; a_req1_wdata = 64'h1234;
    #1;
    checks++;
    if (a_req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL write_ready got %b expected 1", a_req1_ready);
    end
    qa.push_back('{1'b1, 64'h0, cyc + 2});
    @(negedge clock);
    a_req1_valid = 1'b0; a_req1_write = 1'b0;
    checks++;
    if (a_mem_write !== 1'b1 || a_mem_read !== 1'b0 || a_bus_address !== 32'h80 || a_bus_wdata !== 64'h1234) begin
      errors++;
      $display("FAIL write_bus wr=%b rd=%b addr=%h wdata=%h expected 1 0 80 1234",
               a_mem_write, a_mem_read, a_bus_address, a_bus_wdata);
    end
    @(negedge clock);
    checks++;
    if (a_mem_write !== 1'b0 || a_bus_wdata !== '0 || a_rsp0_data !== 64'hDEADBEEF_CAFEF00D) begin
      errors++;
      $display("FAIL write_after wr=%b wdata=%h rsp0_data=%h expected 0 0 deadbeefcafef00d",
               a_mem_write, a_bus_wdata, a_rsp0_data);
    end
    drain();
  endtask

  task automatic test_latency();
    int n;
    n = 0;
    @(negedge clock);
    b_req1_valid = 1'b1; b_req1_write = 1'b0; b_req1_addr = 32'h40; b_req1_size = 2'd3;
    #1;
    checks++;
    if (b_req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL lat_ready got %b expected 1", b_req1_ready);
    end
    qb.push_back('{1'b1, dev_model(32'h40), cyc + 4});
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (k == 1) b_req1_valid = 1'b0;
      if (b_mem_read === 1'b1 && b_bus_address === 32'h40) n++;
      if (k == 4) begin
        checks++;
        if (b_rsp1_valid !== 1'b1 || b_mem_read !== 1'b0) begin
          errors++;
          $display("FAIL lat_resp valid=%b rd=%b at T+4 expected 1 0", b_rsp1_valid, b_mem_read);
        end
      end
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL lat_read_cycles got %0d expected 3", n);
    end
    drain();
  endtask

  task automatic test_tie();
    int exp_g[4];
    int grants;
    int g;
    logic bump0, bump1;
`ifdef ROUND_ROBIN_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{1, 1, 1, 1};
`endif
    grants = 0; bump0 = 1'b0; bump1 = 1'b0;
    @(negedge clock);
    a_req0_valid = 1'b1; a_req0_addr = 32'h100;
    a_req1_valid = 1'b1; a_req1_write = 1'b0; a_req1_addr = 32'h200;
    for (int c = 0; c < 40 && grants < 4; c++) begin
      #1;
      if (a_req0_ready || a_req1_ready) begin
        g = a_req1_ready ? 1 : 0;
        checks++;
        if ((a_req0_ready && a_req1_ready) || g != exp_g[grants]) begin
          errors++;
          $display("FAIL tie_grant%0d got %0d (both=%b) expected %0d", grants, g,
                   a_req0_ready && a_req1_ready, exp_g[grants]);
        end
        qa.push_back('{g[0], dev_model(g != 0 ? a_req1_addr : a_req0_addr), cyc + 2});
        bump0 = (g == 0); bump1 = (g == 1);
        grants++;
      end
      @(negedge clock);
      if (bump0) a_req0_addr = a_req0_addr + 32'd8;
      if (bump1) a_req1_addr = a_req1_addr + 32'd8;
      bump0 = 1'b0; bump1 = 1'b0;
    end
    a_req0_valid = 1'b0; a_req1_valid = 1'b0;
    checks++;
    if (grants != 4) begin
      errors++;
      $display("FAIL tie_timeout grants=%0d expected 4", grants);
    end
    drain();
  endtask

  task automatic test_reset_in_access();
    @(negedge clock);
    b_req0_valid = 1'b1; b_req0_addr = 32'h30; b_req0_size = 2'd3;
    #1;
    checks++;
    if (b_req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_acc_ready got %b expected 1", b_req0_ready);
    end
    @(negedge clock);
    b_req0_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (b_busy !== 1'b0 || b_mem_read !== 1'b0 || b_mem_write !== 1'b0 || b_bus_address !== '0 ||
        b_rsp0_valid !== 1'b0 || b_rsp1_valid !== 1'b0 || b_rsp0_data !== '0 || b_rsp1_data !== '0) begin
      errors++;
      $display("FAIL rst_acc_outputs busy=%b rd=%b addr=%h rsp=%b%b expected all 0",
               b_busy, b_mem_read, b_bus_address, b_rsp0_valid, b_rsp1_valid);
    end
    reset = 1'b0;
    @(negedge clock);
    b_req0_valid = 1'b1; b_req0_addr = 32'h20;
    #1;
    checks++;
    if (b_req0_ready !== 1'b1 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_acc_reaccept ready=%b busy=%b expected 1 0", b_req0_ready, b_busy);
    end
    qb.push_back('{1'b0, dev_model(32'h20), cyc + 4});
    @(negedge clock);
    b_req0_valid = 1'b0;
    drain();
  endtask

  initial begin
    reset = 1'b1;
    a_req0_valid = 1'b0; a_req0_addr = '0; a_req0_size = '0;
    a_req1_valid = 1'b0; a_req1_write = 1'b0; a_req1_addr = '0; a_req1_size = '0; a_req1_wdata = '0;
    b_req0_valid = 1'b0; b_req0_addr = '0; b_req0_size = '0;
    b_req1_valid = 1'b0; b_req1_write = 1'b0; b_req1_addr = '0; b_req1_size = '0; b_req1_wdata = '0;
    repeat (3) @(negedge clock);
    test_reset();
    reset = 1'b0;
    test_single_fetch();
    test_write();
    test_latency();
    test_tie();
    test_reset_in_access();
    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
